wb_cdb_arbiter: RTL
===================

// Module: wb_cdb_arbiter
// PURPOSE
//  Shares one common data bus (CDB) among the FU completion buses (ALU, LSU, BRU), each a wb_pkt_t.
//  Each source has a small FIFO; a round-robin arbiter drains one packet per cycle onto a registered CDB.
//  The CDB feeds PRF write, RS/rename wakeup and ROB completion. Sits between the FUs and the CDB consumers.
// PARAMETERS
//  N_SRC    3  number of completion sources (0=ALU, 1=LSU, 2=BRU)
//  Q_DEPTH  2  per-source FIFO entries; power of two, >=2
//  CNT_W   16  width of the contention statistics counter
// PORTS
//  clk           in   1              rising-edge clock
//  rst_n         in   1              asynchronous active-low reset
//  flush_i       in   1              mispredict/exception flush: drop all buffered completions
//  cdb_stall_i   in   1              CDB consumers cannot accept this cycle
//  src_pkt_i     in   N_SRC x wb_pkt_t  completion packets; .valid is the request
//  src_ready_o   out  N_SRC          source may present a packet (FIFO not full)
//  cdb_o         out  wb_pkt_t       registered CDB broadcast; .valid qualifies the packet
//  cdb_src_o     out  2              source index of the current cdb_o
//  busy_o        out  1              any FIFO non-empty, or cdb_o.valid
//  conflict_cnt_o out CNT_W          cycles where >=2 FIFOs were non-empty (saturating)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all FIFOs empty; rr_ptr=0
//   - cdb_o='0; cdb_src_o=0; conflict_cnt_o=0
//   - src_ready_o=all 1; busy_o=0
//  Enqueue:
//   - packet i is written on an edge where src_pkt_i[i].valid && src_ready_o[i] && !flush_i.
//   - src_ready_o[i] = (count[i] != Q_DEPTH), from registered count only.
//   - There is no combinational path from src_pkt_i or cdb_stall_i to src_ready_o.
//   - A full FIFO therefore reports ready=0 even in a cycle it is popped.
//   - A valid packet presented while ready=0 is the source's to hold; the arbiter never drops it.
//  Arbitration (combinational on FIFO heads, each cycle):
//   - Scan i = rr_ptr, rr_ptr+1, ... mod N_SRC; winner = first non-empty FIFO.
//   - If a winner exists and !cdb_stall_i && !flush_i:
//     - pop the winner;
//     - cdb_o <= head packet with valid=1; cdb_src_o <= winner;
//     - rr_ptr <= (winner+1) mod N_SRC.
//   - Otherwise cdb_o.valid <= 0 (other fields don't-care) and rr_ptr holds.
//   - cdb_o.valid is a single-cycle pulse per packet. The bus is never held across stalls.
//   - Packets with rd_used=0 are still broadcast, because the ROB needs completion.
//  Latency:
//   - Packet accepted on edge E into an empty system: cdb_o.valid=1 after edge E+1.
//   - No input-to-CDB bypass.
//  Simultaneous events:
//   - Push and pop of the same non-full FIFO on one edge: count unchanged, order preserved.
//   - Per-source FIFO order is strict. Cross-source ordering follows round-robin only.
//  Flush (flush_i=1 at an edge):
//   - all FIFOs cleared; cdb_o.valid <= 0; same-cycle inputs dropped; rr_ptr retained.
//   - Flush wins over stall and over enqueue.
//  Wrap-around:
//   - FIFO pointers are log2(Q_DEPTH) bits and wrap naturally.
//   - Full/empty are distinguished by count[i], 0..Q_DEPTH.
//  conflict_cnt_o:
//   - +1 on each edge where >=2 FIFOs were non-empty before the edge, including stall cycles.
//   - Saturates at 2^CNT_W-1. Cleared only by reset.
// TESTING
//  1. Reset, idle -> src_ready_o=3'b111, cdb_o.valid=0, busy_o=0, conflict_cnt_o=0.
//  2. ALU pkt (rob_tag=5, prd=12, data=0xDEADBEEF) on edge E -> after E+1: cdb_o matches, valid=1, cdb_src_o=0; valid=0 after E+2.
//  3. All 3 sources push one pkt on the same edge, rr_ptr=0 -> CDB order ALU, LSU, BRU on 3 consecutive cycles; conflict_cnt_o=2.
//  4. LSU pushes 3 pkts back-to-back, Q_DEPTH=2, stall=1 -> src_ready_o[1]=0 after 2nd push; 3rd held by source.
//     Then stall=0 -> tags drain in push order.
//  5. Two pkts buffered, flush_i=1 with a new ALU pkt presented -> no cdb_o.valid afterward, busy_o=0, new pkt dropped.
//  6. Reset asserted mid-drain with 2 pkts queued -> outputs immediately return to reset values; no CDB pulse after rst_n rises.

Source files
------------

// File: rtl/wb_cdb_arbiter.sv
// Common data bus arbiter: per-source completion FIFOs drained round-robin onto a registered CDB.

package wb_cdb_pkg;

    localparam int unsigned ROB_TAG_W = 6;
    localparam int unsigned PRD_W     = 7;
    localparam int unsigned DATA_W    = 32;

    // Completion / writeback packet carried on each FU bus and on the CDB
    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic                 rd_used;
        logic [PRD_W-1:0]     prd;
        logic [DATA_W-1:0]    data;
    } wb_pkt_t;

endpackage

module wb_cdb_arbiter
    import wb_cdb_pkg::*;
#(
    parameter int unsigned N_SRC   = 3,
    parameter int unsigned Q_DEPTH = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               cdb_stall_i,
    input  wb_pkt_t            src_pkt_i [N_SRC],
    output logic [N_SRC-1:0]   src_ready_o,
    output wb_pkt_t            cdb_o,
    output logic [1:0]         cdb_src_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   conflict_cnt_o
);

    localparam int unsigned PTR_W   = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CNT_Q_W = $clog2(Q_DEPTH + 1);
    localparam int unsigned SRC_W   = 2;

    // FIFO storage and bookkeeping
    wb_pkt_t             mem_q    [N_SRC][Q_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q [N_SRC];
    logic [PTR_W-1:0]    rd_ptr_q [N_SRC];
    logic [CNT_Q_W-1:0]  count_q  [N_SRC];
    logic [CNT_Q_W-1:0]  count_d  [N_SRC];

    logic [N_SRC-1:0]    ready_q;
    logic [N_SRC-1:0]    nonempty_c;
    logic [N_SRC-1:0]    push_c;
    logic [N_SRC-1:0]    pop_c;

    logic [SRC_W-1:0]    rr_ptr_q;
    logic [SRC_W-1:0]    winner_c;
    logic                win_valid_c;
    logic                pop_en_c;
    wb_pkt_t             head_c;
    logic                conflict_c;
    logic                busy_d;

    wb_pkt_t             cdb_q;
    logic [SRC_W-1:0]    cdb_src_q;
    logic                busy_q;
    logic [CNT_W-1:0]    conflict_q;

    assign src_ready_o    = ready_q;
    assign cdb_o          = cdb_q;
    assign cdb_src_o      = cdb_src_q;
    assign busy_o         = busy_q;
    assign conflict_cnt_o = conflict_q;

    // Occupancy flags and contention detect from registered counts
    always_comb begin
        int unsigned n_busy;
        n_busy     = 0;
        nonempty_c = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            nonempty_c[i] = (count_q[i] != '0);
            if (count_q[i] != '0) begin
                n_busy = n_busy + 1;
            end
        end
        conflict_c = (n_busy >= 2);
    end

    // Round-robin scan starting at rr_ptr; first non-empty FIFO wins
    always_comb begin
        int unsigned idx;
        win_valid_c = 1'b0;
        winner_c    = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_SRC;
            if (!win_valid_c && nonempty_c[idx]) begin
                win_valid_c = 1'b1;
                winner_c    = SRC_W'(idx);
            end
        end
        pop_en_c = win_valid_c && !cdb_stall_i && !flush_i;
    end

    // Head packet of the winning FIFO
    always_comb begin
        head_c = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (winner_c == SRC_W'(i)) begin
                head_c = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    // Per-source push/pop and next occupancy; flush clears everything
    always_comb begin
        busy_d = pop_en_c;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            push_c[i] = src_pkt_i[i].valid && ready_q[i] && !flush_i;
            pop_c[i]  = pop_en_c && (winner_c == SRC_W'(i));
            if (flush_i) begin
                count_d[i] = '0;
            end else begin
                count_d[i] = count_q[i] + CNT_Q_W'(push_c[i]) - CNT_Q_W'(pop_c[i]);
            end
            if (count_d[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    // FIFO payload storage; contents are qualified by count, so no reset needed
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (push_c[i]) begin
                mem_q[i][wr_ptr_q[i]] <= src_pkt_i[i];
            end
        end
    end

    // FIFO pointers, counts and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            ready_q <= '1;
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                count_q[i] <= count_d[i];
                ready_q[i] <= (count_d[i] != CNT_Q_W'(Q_DEPTH));
                if (flush_i) begin
                    wr_ptr_q[i] <= '0;
                    rd_ptr_q[i] <= '0;
                end else begin
                    if (push_c[i]) begin
                        wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                    end
                    if (pop_c[i]) begin
                        rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                    end
                end
            end
        end
    end

    // CDB broadcast register and round-robin pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_q     <= '0;
            cdb_src_q <= '0;
            rr_ptr_q  <= '0;
        end else if (pop_en_c) begin
            cdb_q       <= head_c;
            cdb_q.valid <= 1'b1;
            cdb_src_q   <= winner_c;
            rr_ptr_q    <= (winner_c == SRC_W'(N_SRC - 1)) ? '0 : SRC_W'(winner_c + SRC_W'(1));
        end else begin
            cdb_q.valid <= 1'b0;
        end
    end

    // Busy flag and saturating contention counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            conflict_q <= '0;
        end else begin
            busy_q <= busy_d;
            if (conflict_c && (conflict_q != '1)) begin
                conflict_q <= conflict_q + CNT_W'(1);
            end
        end
    end

endmodule
